// File: rtl/snn_bram_pkg.sv
// Shared word map, STATUS layout and decode helpers for the SNN BRAM mailbox.
package snn_bram_pkg;

   localparam int unsigned WORD_CTRL      = 0;
   localparam int unsigned WORD_STATUS    = 1;
   localparam int unsigned WORD_SPIKE_POP = 2;

   localparam int unsigned STAT_BUSY_BIT  = 0;
   localparam int unsigned STAT_OVF_BIT   = 1;
   localparam int unsigned STAT_CNT_LSB   = 8;
   localparam int unsigned STAT_CNT_W     = 8;

   typedef enum logic [1:0] {
      SEL_CTRL,
      SEL_STATUS,
      SEL_SPIKE_POP,
      SEL_STORAGE
   } word_sel_e;

   function automatic int unsigned pop_valid_bit(input int unsigned data_width);
      return data_width - 1;
   endfunction

   // Word 2 only behaves as SPIKE_POP when the spike FIFO is built in.
   function automatic word_sel_e word_sel(input int unsigned idx, input bit fifo_en);
      if (idx == WORD_CTRL)                     return SEL_CTRL;
      if (idx == WORD_STATUS)                   return SEL_STATUS;
      if (fifo_en && (idx == WORD_SPIKE_POP))   return SEL_SPIKE_POP;
      return SEL_STORAGE;
   endfunction

endpackage

// File: rtl/snn_spike_fifo.sv
// Spike index FIFO; a pop frees room for a same-cycle push when full.
module snn_spike_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd];
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   always_ff @(posedge clk) begin
      if (!reset && w_push_ok) r_mem[r_wr] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wr <= r_wr + PW'(1);
         if (w_pop_ok)  r_rd <= r_rd + PW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/snn_bram_responder.sv
// BRAM-mapped mailbox: CTRL/STATUS/SPIKE_POP registers plus plain storage words.
// Define SNN_SPIKE_FIFO_EN to build in the spike FIFO; otherwise word 2 is storage.
module snn_bram_responder #(
   parameter int unsigned BRAM_ADDR_WIDTH = 32,
   parameter int unsigned BRAM_DATA_WIDTH = 128,
   parameter int unsigned BYTES_PER_WIDTH = 16,
   parameter int unsigned DEPTH           = 64,
   parameter int unsigned FIFO_DEPTH      = 16,
   parameter int unsigned NEURON_ID_WIDTH = 10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [BRAM_ADDR_WIDTH-1:0]  bram_addr,
   input  logic                        bram_en,
   input  logic [BYTES_PER_WIDTH-1:0]  bram_we,
   input  logic [BRAM_DATA_WIDTH-1:0]  bram_din,
   output logic [BRAM_DATA_WIDTH-1:0]  bram_dout,
   input  logic                        spike_valid,
   input  logic [NEURON_ID_WIDTH-1:0]  spike_id,
   input  logic                        net_busy,
   output logic                        start_pulse
);

   import snn_bram_pkg::*;

   localparam int unsigned LANE_W  = $clog2(BYTES_PER_WIDTH);
   localparam int unsigned IDX_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned POP_BIT = pop_valid_bit(BRAM_DATA_WIDTH);
`ifdef SNN_SPIKE_FIFO_EN
   localparam bit FIFO_EN = 1'b1;
`else
   localparam bit FIFO_EN = 1'b0;
`endif

   logic [IDX_W-1:0]           w_idx;
   logic                       w_oor;
   logic                       w_rd;
   logic                       w_wr;
   word_sel_e                  w_sel;
   logic [CNT_W-1:0]           w_count;
   logic                       w_ovf;
   logic [NEURON_ID_WIDTH-1:0] w_pop_id;
   logic [BRAM_DATA_WIDTH-1:0] w_rdata;
   logic [BRAM_DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [BRAM_DATA_WIDTH-1:0] r_dout;
   logic                       r_start;
   logic                       w_unused;

   assign w_idx = bram_addr[LANE_W +: IDX_W];
   assign w_oor = |bram_addr[BRAM_ADDR_WIDTH-1:LANE_W+IDX_W];
   assign w_sel = word_sel(32'(w_idx), FIFO_EN);
   assign w_rd  = bram_en && (bram_we == '0);
   assign w_wr  = bram_en && (bram_we != '0) && !w_oor;

`ifdef SNN_SPIKE_FIFO_EN
   logic w_pop;
   logic w_full;
   logic w_empty;
   logic w_ovf_evt;
   logic w_ovf_clr;
   logic r_ovf;

   assign w_pop = w_rd && !w_oor && (w_sel == SEL_SPIKE_POP) && !w_empty;

   snn_spike_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (NEURON_ID_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (spike_valid),
      .i_din   (spike_id),
      .i_pop   (w_pop),
      .o_dout  (w_pop_id),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // A drop in the same cycle as a clear request leaves the flag set.
   assign w_ovf_evt = spike_valid && w_full && !w_pop;
   assign w_ovf_clr = w_wr && (w_sel == SEL_STATUS) && bram_we[0] && bram_din[STAT_OVF_BIT];

   always_ff @(posedge clk) begin
      if (reset)          r_ovf <= 1'b0;
      else if (w_ovf_evt) r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
   end

   assign w_ovf    = r_ovf;
   assign w_unused = ^bram_addr[LANE_W-1:0];
`else
   assign w_count  = '0;
   assign w_ovf    = 1'b0;
   assign w_pop_id = '0;
   assign w_unused = ^{bram_addr[LANE_W-1:0], spike_valid, spike_id};
`endif

   always_comb begin
      w_rdata = '0;
      if (!w_oor) begin
         case (w_sel)
            SEL_CTRL: w_rdata = '0;
            SEL_STATUS: begin
               w_rdata[STAT_BUSY_BIT]               = net_busy;
               w_rdata[STAT_OVF_BIT]                = w_ovf;
               w_rdata[STAT_CNT_LSB +: STAT_CNT_W]  = STAT_CNT_W'(w_count);
            end
            SEL_SPIKE_POP: begin
               if (w_count != '0) begin
                  w_rdata[POP_BIT]               = 1'b1;
                  w_rdata[NEURON_ID_WIDTH-1:0]   = w_pop_id;
               end
            end
            default: w_rdata = r_mem[w_idx];
         endcase
      end
   end

   // Storage is left unreset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (!reset && w_wr && (w_sel == SEL_STORAGE)) begin
         for (int unsigned b = 0; b < BYTES_PER_WIDTH; b++) begin
            if (bram_we[b]) r_mem[w_idx][8*b +: 8] <= bram_din[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout  <= '0;
         r_start <= 1'b0;
      end else begin
         r_start <= w_wr && (w_sel == SEL_CTRL) && bram_we[0] && bram_din[0];
         if (w_rd) r_dout <= w_rdata;
      end
   end

   assign bram_dout   = r_dout;
   assign start_pulse = r_start;

endmodule

// File: tb/tb_snn_bram_responder.sv
// Randomized bench for snn_bram_responder against a queue-based reference model.
module tb_snn_bram_responder;

`ifdef SNN_SPIKE_FIFO_EN
   localparam bit FIFO_EN = 1'b1;
`else
   localparam bit FIFO_EN = 1'b0;
`endif
   localparam int unsigned FD          = 16;
   localparam int unsigned FIRST_STORE = FIFO_EN ? 3 : 2;
   localparam logic [127:0] POP_FLAG   = 128'h1 << 127;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [31:0]  bram_addr = '0;
   logic         bram_en = 1'b0;
   logic [15:0]  bram_we = '0;
   logic [127:0] bram_din = '0;
   logic [127:0] bram_dout;
   logic         spike_valid = 1'b0;
   logic [9:0]   spike_id = '0;
   logic         net_busy = 1'b0;
   logic         start_pulse;

   int unsigned  n_cmp = 0;
   int unsigned  n_bad = 0;

   logic [127:0] m_mem [64];
   logic [9:0]   m_q [$];
   logic         m_ovf = 1'b0;
   logic [127:0] m_dout = '0;
   logic         m_start = 1'b0;

   snn_bram_responder #(
      .BRAM_ADDR_WIDTH (32),
      .BRAM_DATA_WIDTH (128),
      .BYTES_PER_WIDTH (16),
      .DEPTH           (64),
      .FIFO_DEPTH      (FD),
      .NEURON_ID_WIDTH (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bram_addr   (bram_addr),
      .bram_en     (bram_en),
      .bram_we     (bram_we),
      .bram_din    (bram_din),
      .bram_dout   (bram_dout),
      .spike_valid (spike_valid),
      .spike_id    (spike_id),
      .net_busy    (net_busy),
      .start_pulse (start_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference behaviour for one clock edge, from the current input values.
   task automatic model_step();
      int unsigned idx;
      bit oor, rd, wr, pop, clr, evt;
      if (reset) begin
         m_dout  = '0;
         m_start = 1'b0;
         m_ovf   = 1'b0;
         m_q.delete();
         return;
      end
      idx = int'(bram_addr[9:4]);
      oor = (bram_addr[31:10] != 0);
      rd  = bram_en && (bram_we == 0);
      wr  = bram_en && (bram_we != 0) && !oor;
      pop = FIFO_EN && rd && !oor && (idx == 2) && (m_q.size() > 0);
      m_start = wr && (idx == 0) && bram_we[0] && bram_din[0];
      if (rd) begin
         if (oor || idx == 0)          m_dout = '0;
         else if (idx == 1)            m_dout = 128'(net_busy) | (128'(m_ovf) << 1) | (128'(m_q.size()) << 8);
         else if (idx == 2 && FIFO_EN) m_dout = pop ? (POP_FLAG | 128'(m_q[0])) : '0;
         else                          m_dout = m_mem[idx];
      end
      if (wr && idx >= FIRST_STORE)
         for (int b = 0; b < 16; b++)
            if (bram_we[b]) m_mem[idx][8*b +: 8] = bram_din[8*b +: 8];
      clr = wr && (idx == 1) && bram_we[0] && bram_din[1];
      if (pop) void'(m_q.pop_front());
      evt = 1'b0;
      if (FIFO_EN && spike_valid) begin
         if (m_q.size() < FD) m_q.push_back(spike_id);
         else evt = 1'b1;
      end
      if (evt)      m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
   endtask

   task automatic cycle(input logic [31:0] a, input logic en, input logic [15:0] we,
                        input logic [127:0] din, input logic sv, input logic [9:0] sid,
                        input logic rst);
      @(negedge clk);
      bram_addr   = a;
      bram_en     = en;
      bram_we     = we;
      bram_din    = din;
      spike_valid = sv;
      spike_id    = sid;
      reset       = rst;
      net_busy    = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_step();
      #1;
      check_eq("dout", bram_dout, m_dout);
      check_eq("start", 128'(start_pulse), 128'(m_start));
   endtask

   task automatic wr(input int unsigned w, input logic [15:0] we, input logic [127:0] d);
      cycle(32'(w << 4), 1'b1, we, d, 1'b0, '0, 1'b0);
   endtask

   task automatic rd(input int unsigned w);
      cycle(32'(w << 4), 1'b1, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic push(input logic [9:0] id);
      cycle('0, 1'b0, '0, '0, 1'b1, id, 1'b0);
   endtask

   task automatic idle();
      cycle('0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      logic [31:0]  a;
      logic [15:0]  we;
      int unsigned  w;

      cycle('0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
      check_eq("rst_dout", bram_dout, '0);
      check_eq("rst_start", 128'(start_pulse), '0);
      cycle('0, 1'b0, '0, '0, 1'b0, '0, 1'b0);

      for (int unsigned i = 2; i < 64; i++)
         wr(i, 16'hFFFF, {$urandom(), $urandom(), $urandom(), $urandom()});

      rd(1);
      check_eq("status_idle", bram_dout & ~128'h1, '0);

      wr(5, 16'hFFFF, {16{8'h55}});
      wr(5, 16'h00FF, {16{8'hAA}});
      rd(5);
      check_eq("byte_merge", bram_dout, {{8{8'h55}}, {8{8'hAA}}});

      wr(0, 16'h0001, 128'h1);
      check_eq("start_hi", 128'(start_pulse), 128'h1);
      idle();
      check_eq("start_lo", 128'(start_pulse), '0);
      wr(0, 16'h0001, 128'h1);
      wr(0, 16'h0001, 128'h1);
      check_eq("start_b2b", 128'(start_pulse), 128'h1);
      wr(0, 16'h0002, 128'h1);
      check_eq("start_we_lane", 128'(start_pulse), '0);

      cycle(32'h0000_0450, 1'b1, 16'hFFFF, '1, 1'b0, '0, 1'b0);
      rd(5);
      cycle(32'h0000_0450, 1'b1, '0, '0, 1'b0, '0, 1'b0);
      check_eq("oor_read", bram_dout, '0);

      push(10'd3);
      push(10'd7);
      push(10'd1023);
      rd(2);
`ifdef SNN_SPIKE_FIFO_EN
      check_eq("pop_3", bram_dout, POP_FLAG | 128'd3);
`endif
      rd(2);
`ifdef SNN_SPIKE_FIFO_EN
      check_eq("pop_7", bram_dout, POP_FLAG | 128'd7);
`endif
      rd(2);
`ifdef SNN_SPIKE_FIFO_EN
      check_eq("pop_1023", bram_dout, POP_FLAG | 128'd1023);
`endif
      rd(2);
`ifdef SNN_SPIKE_FIFO_EN
      check_eq("pop_empty", bram_dout, '0);
`endif

      for (int unsigned i = 0; i < 17; i++) push(10'(100 + i));
      rd(1);
`ifdef SNN_SPIKE_FIFO_EN
      check_eq("ovf_count", 128'(bram_dout[15:8]), 128'd16);
      check_eq("ovf_set", 128'(bram_dout[1]), 128'h1);
`else
      check_eq("nofifo_status", bram_dout & ~128'h1, '0);
`endif
      wr(1, 16'h0001, 128'h2);
      rd(1);
      check_eq("ovf_clr", 128'(bram_dout[1]), '0);

      cycle(32'h20, 1'b1, '0, '0, 1'b1, 10'd9, 1'b0);
      rd(1);
`ifdef SNN_SPIKE_FIFO_EN
      check_eq("full_pp_count", 128'(bram_dout[15:8]), 128'd16);
      check_eq("full_pp_ovf", 128'(bram_dout[1]), '0);
`endif
      for (int unsigned i = 0; i < 16; i++) rd(2);
`ifdef SNN_SPIKE_FIFO_EN
      check_eq("full_pp_last", bram_dout, POP_FLAG | 128'd9);
`endif

      cycle(32'h20, 1'b1, '0, '0, 1'b1, 10'd42, 1'b0);
`ifdef SNN_SPIKE_FIFO_EN
      check_eq("empty_pp_dout", bram_dout, '0);
`endif
      rd(1);
`ifdef SNN_SPIKE_FIFO_EN
      check_eq("empty_pp_count", 128'(bram_dout[15:8]), 128'd1);
`endif
      rd(2);

      for (int unsigned i = 0; i < 5; i++) push(10'(200 + i));
      wr(0, 16'h0001, 128'h1);
      cycle(32'h10, 1'b1, '0, '0, 1'b0, '0, 1'b1);
      check_eq("midrst_dout", bram_dout, '0);
      check_eq("midrst_start", 128'(start_pulse), '0);
      rd(1);
      check_eq("midrst_count", 128'(bram_dout[15:8]), '0);

      for (int unsigned n = 0; n < 2500; n++) begin
         w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
         a = 32'(w << 4) | 32'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(10, 31));
         case ($urandom_range(0, 3))
            0:       we = 16'hFFFF;
            1:       we = 16'($urandom());
            default: we = '0;
         endcase
         cycle(a, 1'($urandom_range(0, 3) != 0), we,
               {$urandom(), $urandom(), $urandom(), $urandom()},
               1'($urandom_range(0, 4) < 2), 10'($urandom_range(0, 1023)),
               1'($urandom_range(0, 299) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
